// File: rtl/musa_mem_arbiter_if.sv
// Request/grant/response bundle between MUSA fetch+data ports, the arbiter and the memory.
// The arbiter takes the slave side; requesters and memory sit on the master side.
interface musa_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/musa_mem_arbiter.sv
// Single-port memory arbiter: data has priority, a bounded run counter lets a waiting fetch in.
// Grants are combinational; read data returns one cycle later to the port recorded in rd_owner.
module musa_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_RUN   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  musa_mem_arbiter_if.slave bus
);

  localparam logic [3:0] RUN_MAX = 4'(DATA_RUN);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  logic [3:0] r_run_cnt;
  owner_e     r_rd_owner;

  logic w_d_win;
  logic w_f_win;
  logic w_d_gnt;
  logic w_f_gnt;

  // Data wins unless a fetch has already waited through RUN_MAX data grants.
  always_comb begin
    w_d_win = bus.d_req & (~bus.if_req | (r_run_cnt < RUN_MAX));
    w_f_win = bus.if_req & ~w_d_win;
    w_d_gnt = w_d_win & ~i_rst;
    w_f_gnt = w_f_win & ~i_rst;
  end

  assign bus.if_gnt    = w_f_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_f_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_addr  = w_d_win ? bus.d_addr : bus.if_addr;
  assign bus.mem_wdata = w_d_win ? bus.d_wdata : '0;

  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.if_rvalid = (r_rd_owner == OWN_FETCH);
  assign bus.d_rvalid  = (r_rd_owner == OWN_DATA);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run_cnt  <= '0;
      r_rd_owner <= OWN_NONE;
    end else begin
      if (!bus.if_req || w_f_gnt) begin
        r_run_cnt <= '0;
      end else if (w_d_gnt && (r_run_cnt < RUN_MAX)) begin
        r_run_cnt <= r_run_cnt + 4'd1;
      end

      if (w_f_gnt) begin
        r_rd_owner <= OWN_FETCH;
      end else if (w_d_gnt && !bus.d_we) begin
        r_rd_owner <= OWN_DATA;
      end else begin
        r_rd_owner <= OWN_NONE;
      end
    end
  end

endmodule

// File: doc/musa_mem_arbiter.md
# musa_mem_arbiter

Arbiter that shares the MUSA processor's single-port synchronous memory between the instruction-fetch port and the data load/store port of the dataPath. It issues at most one memory access per cycle. Data accesses have priority over fetches, and a bounded-run counter prevents fetch starvation. It tracks which port owns each in-flight read so that read data returns to the correct requester one cycle after the grant.

## Interface
Parameters:
- DATA_WIDTH, 32, width of memory words and all data buses
- ADDR_WIDTH, 10, word-address width
- DATA_RUN, 4, maximum consecutive data grants while a fetch is waiting (range 1..15)

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high
- if_gnt  out  1  fetch access issued this cycle
- if_rvalid  out  1  if_rdata is valid this cycle
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  d_rdata is valid this cycle (reads only)
- d_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- Grant decision is combinational from the current cycle's requests and the registered run counter:
  - only d_req: data wins
  - only if_req: fetch wins
  - both, with run_cnt < DATA_RUN: data wins
  - both, with run_cnt == DATA_RUN: fetch wins
  - neither: no grant, mem_en=0
- run_cnt register (4 bits):
  - increments on a data grant while if_req is also high, saturating at DATA_RUN
  - clears on any fetch grant, and on any cycle where if_req is low
- Memory mux:
  - mem_en = if_gnt | d_gnt
  - mem_we = d_gnt & d_we
  - mem_addr and mem_wdata come from the winning port
  - mem_wdata = 0 when the fetch port wins
- Owner register rd_owner (2 bits: none / fetch / data) records the port of a read issued this cycle. Writes record none.
- Next cycle, mem_rdata is routed to both if_rdata and d_rdata. Only the rvalid of rd_owner is asserted.
- Only one of if_gnt and d_gnt is ever high in a cycle. Only one of if_rvalid and d_rvalid is ever high in a cycle.
- Back-to-back accesses are fully pipelined: a new grant may issue in the same cycle that the previous read's rvalid is asserted.

## Timing
- Grant in cycle N comes with memory control in cycle N. Read data and rvalid appear in cycle N+1, for a latency of 1.
- Writes complete at the cycle-N edge and produce no rvalid.
- A requester sees its request consumed on the edge where gnt is high. It may change address or deassert req in cycle N+1.
- Reset values while rst is high:
  - if_gnt, d_gnt, mem_en, mem_we: 0 (gated combinationally by rst)
  - if_rvalid, d_rvalid: 0
  - rd_owner = none, run_cnt = 0
  - rdata outputs follow mem_rdata but are don't-care
- Reset asserted with a read in flight: the read is dropped and no rvalid is asserted after release.
- First grant is possible in the first cycle rst is low.
- Fetch wait bound: with d_req held continuously, a pending fetch is granted within DATA_RUN+1 cycles.
- DATA_RUN saturation: run_cnt never exceeds DATA_RUN and never wraps.

## Test plan
- Fetch-only stream: if_req held 5 cycles at addresses 0..4, memory preloaded mem[i]=i+100. Required: if_gnt high 5 cycles, if_rvalid cycles 2..6, if_rdata = 100..104, d_gnt never high.
- Data write then read: d_we=1, d_addr=7, d_wdata=0xDEADBEEF, then a read of address 7. Required: no rvalid for the write, d_rvalid one cycle after the read grant, d_rdata=0xDEADBEEF.
- Contention with DATA_RUN=4: both requests held for 10 cycles. Required grant pattern D,D,D,D,F,D,D,D,D,F; if_rvalid and d_rvalid each follow their own grants.
- Fetch arriving mid data burst: if_req rises while run_cnt=0. Required: fetch granted after exactly 4 data grants, never earlier than the bound allows, and run_cnt is 0 after the fetch grant.
- Reset mid-read: rst pulsed asynchronously between a data read grant and the next edge. Required: no d_rvalid after release, all outputs 0 during reset, and a normal fetch is granted in the first cycle after release.
- Alternating single requests: if_req only, then d_req only, repeated. Required: a grant every cycle, run_cnt stays 0, and rvalid goes to the correct port each cycle.
